mac_multiplier: RTL and testbench



---
 rtl/mac_multiplier_pkg.sv | 13 +
 rtl/mac_multiplier_step.sv | 24 ++
 rtl/mac_multiplier.sv | 97 +++++++++
 tb/tb_mac_multiplier.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mac_multiplier_pkg.sv
// Shared width constants for the divider / multiply-accumulate pair.
// Both blocks size themselves from these constants so their widths stay aligned.
package mac_multiplier_pkg;

    localparam int unsigned DIV_M = 26;
    localparam int unsigned DIV_N = 14;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_multiplier_step.sv
// One shift-and-add iteration: conditionally add the shifted multiplicand,
// then advance the multiplicand and multiplier by one bit position.
module mac_multiplier_step #(
    parameter int unsigned P = 40,
    parameter int unsigned N = 14
) (
    input  logic [P-1:0] acc,
    input  logic [P-1:0] mc,
    input  logic [N-1:0] mr,
    output logic [P-1:0] acc_nxt_c,
    output logic [P-1:0] mc_nxt_c,
    output logic [N-1:0] mr_nxt_c
);

    always_comb begin
        acc_nxt_c = acc;
        if (mr[0]) begin
            acc_nxt_c = acc + mc;
        end
        mc_nxt_c = mc << 1;
        mr_nxt_c = mr >> 1;
    end

endmodule

// File: rtl/mac_multiplier.sv
// Sequential multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per clock, en / multiplier_ok handshake like the divider.
module mac_multiplier
    import mac_multiplier_pkg::*;
#(
    parameter int unsigned M = DIV_M,
    parameter int unsigned N = DIV_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [M-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    input  logic [N-1:0]     addend,
    output logic [M+N-1:0]   product,
    output logic             multiplier_ok
);

    localparam int unsigned P  = M + N;
    localparam int unsigned CW = cnt_width(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [P-1:0]    acc;
    logic [P-1:0]    mc_r;
    logic [N-1:0]    mr_r;
    logic [CW-1:0]   cnt;

    logic [P-1:0]    acc_nxt_c;
    logic [P-1:0]    mc_nxt_c;
    logic [N-1:0]    mr_nxt_c;

    mac_multiplier_step #(
        .P (P),
        .N (N)
    ) u_step (
        .acc       (acc),
        .mc        (mc_r),
        .mr        (mr_r),
        .acc_nxt_c (acc_nxt_c),
        .mc_nxt_c  (mc_nxt_c),
        .mr_nxt_c  (mr_nxt_c)
    );

    // Accumulator is internal; product is only loaded on the completion edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            mc_r          <= '0;
            mr_r          <= '0;
            cnt           <= '0;
            product       <= '0;
            multiplier_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        mc_r  <= P'(multiplicand);
                        mr_r  <= multiplier;
                        acc   <= P'(addend);
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_nxt_c;
                    mc_r <= mc_nxt_c;
                    mr_r <= mr_nxt_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        product       <= acc_nxt_c;
                        multiplier_ok <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // No automatic restart: en must drop before a new operation.
                    if (!en) begin
                        multiplier_ok <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    multiplier_ok <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_multiplier.sv
// Randomized and directed bench for mac_multiplier against an A*B+C model.
module tb_mac_multiplier;

    localparam int unsigned M = 26;
    localparam int unsigned N = 14;
    localparam int unsigned P = M + N;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [M-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic [N-1:0]  addend;
    logic [P-1:0]  product;
    logic          multiplier_ok;

    int n_checks = 0;
    int n_errs   = 0;
    logic [63:0] model_product;

    mac_multiplier dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .addend        (addend),
        .product       (product),
        .multiplier_ok (multiplier_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mac(input logic [M-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] c);
        return 64'(a) * 64'(b) + 64'(c);
    endfunction

    // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic run_op(input logic [M-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                          input int hold, input bit scramble, input bit detail);
        logic [63:0] exp;
        exp          = ref_mac(a, b, c);
        en           = 1'b1;
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        @(posedge clk);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (detail) begin
                check("busy_ok", 64'(multiplier_ok), 64'd0);
                check("busy_product_held", 64'(product), model_product);
            end
            if (scramble) begin
                multiplicand = M'($urandom);
                multiplier   = N'($urandom);
                addend       = N'($urandom);
                en           = (k < N) ? 1'($urandom) : 1'b1;
            end else begin
                en = 1'b1;
            end
        end
        @(negedge clk);
        check("done_ok", 64'(multiplier_ok), 64'd1);
        check("done_product", 64'(product), exp);
        model_product = exp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_ok", 64'(multiplier_ok), 64'd1);
            if (detail) check("hold_product", 64'(product), exp);
        end
        en = 1'b0;
        @(negedge clk);
        check("exit_ok", 64'(multiplier_ok), 64'd0);
        if (detail) check("exit_product", 64'(product), exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        multiplicand = '0; multiplier = '0; addend = '0;
        model_product = 64'd0;
        repeat (2) @(negedge clk);
        check("reset_product", 64'(product), 64'd0);
        check("reset_ok", 64'(multiplier_ok), 64'd0);
        rst = 1'b0;

        // Divider round trip, result held while en stays high.
        run_op(26'd57699, 14'h2CB, 14'd127, 4, 1'b0, 1'b1);
        check("roundtrip_value", model_product, 64'd41254912);
        run_op(26'h3FFFFFF, 14'd0, 14'h1234, 1, 1'b0, 1'b1);
        run_op(26'h3FFFFFF, 14'h3FFF, 14'h3FFF, 1, 1'b0, 1'b1);
        check("max_value", model_product, 64'hFFFC000000);
        run_op(26'd0, 14'h155, 14'h2AA, 0, 1'b0, 1'b1);
        run_op(26'd0, 14'd0, 14'd0, 0, 1'b0, 1'b1);
        // Fast repeat with inputs disturbed during BUSY.
        run_op(26'd123456, 14'd999, 14'd17, 6, 1'b0, 1'b1);
        run_op(26'd3, 14'd5, 14'd0, 2, 1'b1, 1'b1);

        // Abort at iteration 7: product clears, no partial result appears.
        en = 1'b1; multiplicand = 26'd1000; multiplier = 14'd1000; addend = 14'd5;
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        model_product = 64'd0;
        check("abort_product", 64'(product), 64'd0);
        check("abort_ok", 64'(multiplier_ok), 64'd0);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("abort_idle_ok", 64'(multiplier_ok), 64'd0);
        end
        check("abort_idle_product", 64'(product), 64'd0);
        run_op(26'd1000, 14'd1000, 14'd5, 0, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            run_op(M'($urandom), N'($urandom), N'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
